// File: rtl/pipe_hazard_controller.sv
// Hazard sequencing for the 5-stage RV32I pipeline: stage enables, D/E flushes,
// Execute forwarding selects and a dmem wait FSM. Optional stats under HAZARD_STATS_EN.
module pipe_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             async_reset,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic             mem_read_E,
  input  logic             branch_taken_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             reg_write_M,
  input  logic             reg_write_W,
  input  logic             dmem_req_M,
  input  logic             dmem_ack,
  output logic             enable_F,
  output logic             enable_D,
  output logic             enable_E,
  output logic             enable_M,
  output logic             enable_W,
  output logic             sync_reset_D,
  output logic             sync_reset_E,
  output logic [1:0]       fwd_A_E,
  output logic [1:0]       fwd_B_E,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } state_t;

  state_t          r_state;
  logic [WC_W-1:0] r_wait_cnt;
  logic            r_mem_error;

  logic w_timeout_hit;
  logic w_mem_stall;
  logic w_load_use;

  assign w_timeout_hit = (r_state == ST_MEM_WAIT) && (r_wait_cnt == WC_LAST);
  assign w_mem_stall   = dmem_req_M && !dmem_ack && !w_timeout_hit;
  assign w_load_use    = mem_read_E && (Rd_E != 5'd0) &&
                         ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Reset level gates every combinational output so the pipe is frozen while held.
  always_comb begin
    enable_F     = 1'b0;
    enable_D     = 1'b0;
    enable_E     = 1'b0;
    enable_M     = 1'b0;
    enable_W     = 1'b0;
    sync_reset_D = 1'b1;
    sync_reset_E = 1'b1;
    fwd_A_E      = 2'b00;
    fwd_B_E      = 2'b00;
    if (async_reset) begin
      fwd_A_E = fwd_sel(Rs1_E, reg_write_M, Rd_M, reg_write_W, Rd_W);
      fwd_B_E = fwd_sel(Rs2_E, reg_write_M, Rd_M, reg_write_W, Rd_W);
      if (w_mem_stall) begin
        // whole pipe holds; pending branch / load-use re-evaluated after release
      end else if (branch_taken_E) begin
        {enable_F, enable_D, enable_E, enable_M, enable_W} = '1;
        sync_reset_D = 1'b0;
        sync_reset_E = 1'b0;
      end else if (w_load_use) begin
        {enable_E, enable_M, enable_W} = '1;
        sync_reset_E = 1'b0;
      end else begin
        {enable_F, enable_D, enable_E, enable_M, enable_W} = '1;
      end
    end
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_mem_error <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (dmem_req_M && !dmem_ack) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= WC_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ack) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (w_timeout_hit) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_mem_error <= 1'b1;
          end else if (r_wait_cnt != WC_LAST) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign mem_error = r_mem_error;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_stall_evt;
  logic             w_flush_evt;

  assign w_stall_evt = w_mem_stall || (w_load_use && !branch_taken_E);
  assign w_flush_evt = branch_taken_E && !w_mem_stall;

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_flush_evt && (r_flush_count != '1))
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Randomized + directed bench for pipe_hazard_controller against a cycle-level reference model.
module tb_pipe_hazard_controller;

  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          async_reset;
  logic [4:0]    Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic          mem_read_E, branch_taken_E, reg_write_M, reg_write_W;
  logic          dmem_req_M, dmem_ack;
  logic          enable_F, enable_D, enable_E, enable_M, enable_W;
  logic          sync_reset_D, sync_reset_E;
  logic [1:0]    fwd_A_E, fwd_B_E;
  logic          mem_error;
  logic [CW-1:0] stall_cycles, flush_count;

  pipe_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .async_reset(async_reset),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .mem_read_E(mem_read_E), .branch_taken_E(branch_taken_E),
    .Rd_M(Rd_M), .Rd_W(Rd_W), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
    .dmem_req_M(dmem_req_M), .dmem_ack(dmem_ack),
    .enable_F(enable_F), .enable_D(enable_D), .enable_E(enable_E),
    .enable_M(enable_M), .enable_W(enable_W),
    .sync_reset_D(sync_reset_D), .sync_reset_E(sync_reset_E),
    .fwd_A_E(fwd_A_E), .fwd_B_E(fwd_B_E), .mem_error(mem_error),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: how many cycles the current dmem access has already waited
  // (0 = no access in progress), sticky error flag and saturating event counts.
  int unsigned m_waited;
  bit          m_err;
  int unsigned m_stall, m_flush;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (reg_write_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
    if (reg_write_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_mem_stall();
    bit gave_up = (m_waited == TO - 1);
    return dmem_req_M && !dmem_ack && !gave_up;
  endfunction

  function automatic bit ref_load_use();
    return mem_read_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D);
  endfunction

  task automatic model_reset();
    m_waited = 0;
    m_err    = 0;
    m_stall  = 0;
    m_flush  = 0;
  endtask

  task automatic check_outputs();
    logic [4:0] en;
    logic [1:0] sr, fa, fb;
    bit ms = ref_mem_stall();
    bit lu = ref_load_use();
    fa = fwd_ref(Rs1_E);
    fb = fwd_ref(Rs2_E);
    if (!async_reset) begin
      en = 5'b00000; sr = 2'b11; fa = 2'b00; fb = 2'b00;
    end else if (ms) begin
      en = 5'b00000; sr = 2'b11;
    end else if (branch_taken_E) begin
      en = 5'b11111; sr = 2'b00;
    end else if (lu) begin
      en = 5'b00111; sr = 2'b10;
    end else begin
      en = 5'b11111; sr = 2'b11;
    end
    check("enables_FDEMW", {27'd0, enable_F, enable_D, enable_E, enable_M, enable_W}, {27'd0, en});
    check("sync_reset_DE", {30'd0, sync_reset_D, sync_reset_E}, {30'd0, sr});
    check("fwd_A_E", {30'd0, fwd_A_E}, {30'd0, fa});
    check("fwd_B_E", {30'd0, fwd_B_E}, {30'd0, fb});
    check("mem_error", {31'd0, mem_error}, {31'd0, m_err});
`ifdef HAZARD_STATS_EN
    check("stall_cycles", {24'd0, stall_cycles}, m_stall);
    check("flush_count", {24'd0, flush_count}, m_flush);
`else
    check("stall_cycles", {24'd0, stall_cycles}, 32'd0);
    check("flush_count", {24'd0, flush_count}, 32'd0);
`endif
  endtask

  // Called right at the rising edge, while the pre-edge inputs are still applied.
  task automatic advance();
    bit ms, lu;
    if (!async_reset) return;
    ms = ref_mem_stall();
    lu = ref_load_use();
    if ((ms || (lu && !branch_taken_E)) && m_stall < SAT) m_stall++;
    if (branch_taken_E && !ms && m_flush < SAT) m_flush++;
    if (m_waited == 0) begin
      if (dmem_req_M && !dmem_ack) m_waited = 1;
    end else if (dmem_ack) begin
      m_waited = 0;
    end else if (m_waited == TO - 1) begin
      m_waited = 0;
      m_err    = 1;
    end else begin
      m_waited++;
    end
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clock);
    advance();
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W} = '0;
    {mem_read_E, branch_taken_E, reg_write_M, reg_write_W, dmem_req_M, dmem_ack} = '0;
  endtask

  // Small register space so matches, x0 cases and M/W ties occur often.
  task automatic random_inputs();
    Rs1_D = 5'($urandom_range(0, 3));
    Rs2_D = 5'($urandom_range(0, 3));
    Rs1_E = 5'($urandom_range(0, 3));
    Rs2_E = 5'($urandom_range(0, 3));
    Rd_E  = 5'($urandom_range(0, 3));
    Rd_M  = 5'($urandom_range(0, 3));
    Rd_W  = 5'($urandom_range(0, 3));
    mem_read_E     = ($urandom_range(0, 99) < 40);
    branch_taken_E = ($urandom_range(0, 99) < 15);
    reg_write_M    = ($urandom_range(0, 99) < 60);
    reg_write_W    = ($urandom_range(0, 99) < 60);
    dmem_req_M     = ($urandom_range(0, 99) < 50);
    dmem_ack       = ($urandom_range(0, 99) < 30);
  endtask

  initial begin
    async_reset = 1'b0;
    model_reset();
    random_inputs();
    #2 check_outputs();
    #10 check_outputs();
    async_reset = 1'b1;
    @(posedge clock);
    #1;

    // T1 load-use bubble then normal flow
    clear_inputs();
    mem_read_E = 1; Rd_E = 5; Rs1_D = 5;
    step();
    clear_inputs();
    step();

    // T2 branch overrides load-use
    mem_read_E = 1; Rd_E = 5; Rs2_D = 5; branch_taken_E = 1;
    step();
    clear_inputs();

    // T3 ack arrives on the fourth request cycle
    dmem_req_M = 1;
    repeat (3) step();
    dmem_ack = 1;
    step();
    clear_inputs();
    step();

    // T4 request never acknowledged: timeout release and sticky error
    dmem_req_M = 1;
    repeat (6) step();
    clear_inputs();
    repeat (2) step();

    // T5 forwarding priority and x0
    Rs1_E = 7; Rs2_E = 7; Rd_M = 7; reg_write_M = 1; Rd_W = 7; reg_write_W = 1;
    step();
    Rd_M = 0;
    step();
    Rs1_E = 0; Rs2_E = 0; Rd_M = 0; Rd_W = 0;
    step();
    clear_inputs();

    repeat (500) begin
      random_inputs();
      step();
    end

    // T6 asynchronous reset in the middle of a memory wait
    clear_inputs();
    dmem_req_M = 1;
    step();
    #2 async_reset = 1'b0;
    #1 model_reset();
    check_outputs();
    @(posedge clock);
    advance();
    #3 check_outputs();
    async_reset = 1'b1;
    clear_inputs();
    step();

    repeat (300) begin
      random_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
